// File: rtl/team_08_lcd_bus_arbiter.sv
// team_08_lcd_bus_arbiter: round-robin owner selection and 8080-style write sequencing for the shared display bus
module team_08_lcd_bus_arbiter #(
  parameter int NREQ      = 3,
  parameter int DW        = 8,
  parameter int WR_CYCLES = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ-1:0]         req_dc,
  input  logic [NREQ-1:0]         req_lock,
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [DW-1:0]           lcd_data,
  output logic                    lcd_dc,
  output logic                    lcd_cs_n,
  output logic                    lcd_wr_n
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d, owner_q, owner_d, win, sel, idx;
  logic [BW-1:0]   burst_q, burst_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [DW-1:0]   data_q;
  logic            dc_q, cs_n_q, wr_n_q, busy_q, win_vld, chain, load;
  logic [NREQ-1:0] ack_q;
  logic [DW-1:0]   words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[g*DW +: DW];
  end

  assign chain = en & req[owner_q] & req_lock[owner_q] & (burst_q < BW'(MAX_BURST));

  // round-robin search: first requester after the last grant; the loop runs backwards so the nearest one wins
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int o = NREQ; o >= 1; o--) begin
      idx = IW'((int'(last_q) + o) % NREQ);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // next-state: grant from IDLE, fixed-length word phases, chain or release at the end of HOLD
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    sel     = owner_q;
    case (state_q)
      IDLE: if (en && win_vld) begin
        state_d = SETUP;
        load    = 1'b1;
        sel     = win;
        owner_d = win;
        last_d  = win;
        burst_d = BW'(1);
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 4'(WR_CYCLES - 1);
      end
      STROBE: begin
        state_d = (cnt_q == 4'd0) ? HOLD : STROBE;
        cnt_d   = cnt_q - 4'd1;
      end
      HOLD: if (chain) begin
        state_d = SETUP;
        load    = 1'b1;
        burst_d = burst_q + BW'(1);
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered pin drive; strobes are decoded from the next state so every output is a flop
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      owner_q <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      dc_q    <= 1'b0;
      ack_q   <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      data_q  <= load ? words[sel] : data_q;
      dc_q    <= load ? req_dc[sel] : dc_q;
      ack_q   <= load ? NREQ'(1) << sel : '0;
      cs_n_q  <= state_d == IDLE;
      wr_n_q  <= state_d != STROBE;
      busy_q  <= state_d != IDLE;
    end
  end

  assign ack      = ack_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign lcd_data = data_q;
  assign lcd_dc   = dc_q;
  assign lcd_cs_n = cs_n_q;
  assign lcd_wr_n = wr_n_q;
endmodule
